// File: rtl/gpr_wb.sv
// GPR write-back stage: retires ALU results, waits for load data, extracts/extends lanes, drives the GPR write port.
// Optional macro GPR_WB_FWD_EN adds a combinational forwarding port carrying next cycle's write.
`ifndef GPR_BIT
`define GPR_BIT 32
`endif
`ifndef GPR_ADR
`define GPR_ADR 5
`endif

module gpr_wb #(
  parameter int unsigned LD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [`GPR_ADR-1:0]   in_addr_reg,
  input  logic                  in_we,
  input  logic                  in_is_load,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_sext,
  input  logic [1:0]            in_ld_off,
  input  logic [`GPR_BIT-1:0]   in_alu_res,
  input  logic                  mem_rvalid,
  input  logic [`GPR_BIT-1:0]   mem_rdata,
  output logic                  gpr_we,
  output logic [`GPR_ADR-1:0]   gpr_waddr,
  output logic [`GPR_BIT-1:0]   gpr_wdata,
  output logic                  busy,
  output logic [`GPR_ADR-1:0]   busy_addr,
  output logic                  ld_err
`ifdef GPR_WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [`GPR_ADR-1:0]   fwd_addr,
  output logic [`GPR_BIT-1:0]   fwd_data
`endif
);

  localparam int unsigned GprBit = `GPR_BIT;
  localparam int unsigned GprAdr = `GPR_ADR;
  localparam int unsigned TmrW   = $clog2(LD_TIMEOUT + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [GprAdr-1:0]   ld_addr_q, ld_addr_d;
  logic [1:0]          ld_size_q, ld_size_d;
  logic                ld_sext_q, ld_sext_d;
  logic [1:0]          ld_off_q, ld_off_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic                ld_err_q, ld_err_d;
  logic                gpr_we_q, gpr_we_d;
  logic [GprAdr-1:0]   gpr_waddr_q, gpr_waddr_d;
  logic [GprBit-1:0]   gpr_wdata_q, gpr_wdata_d;

  logic                wr_en;
  logic                wr_fire;
  logic [GprAdr-1:0]   wr_addr;
  logic [GprBit-1:0]   wr_data;
  logic [GprBit-1:0]   ld_data;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;

  // Lane extraction and extension of the returning load word
  always_comb begin
    byte_lane = 8'(mem_rdata >> {ld_off_q, 3'b000});
    half_lane = 16'(mem_rdata >> {ld_off_q[1], 4'b0000});
    ld_data   = mem_rdata;
    case (ld_size_q)
      2'b00:   ld_data = ld_sext_q ? {{(GprBit-8){byte_lane[7]}}, byte_lane}
                                   : GprBit'(byte_lane);
      2'b01:   ld_data = ld_sext_q ? {{(GprBit-16){half_lane[15]}}, half_lane}
                                   : GprBit'(half_lane);
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    ld_size_d = ld_size_q;
    ld_sext_d = ld_sext_q;
    ld_off_d  = ld_off_q;
    tmr_d     = tmr_q;
    ld_err_d  = ld_err_q;
    wr_en     = 1'b0;
    wr_addr   = in_addr_reg;
    wr_data   = in_alu_res;
    case (state_q)
      IDLE: begin
        if (in_valid && in_we) begin
          if (in_is_load) begin
            ld_addr_d = in_addr_reg;
            ld_size_d = in_ld_size;
            ld_sext_d = in_ld_sext;
            ld_off_d  = in_ld_off;
            tmr_d     = '0;
            state_d   = WAIT_LD;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      WAIT_LD: begin
        wr_addr = ld_addr_q;
        wr_data = ld_data;
        // Data arriving on the last permitted cycle beats the timeout
        if (mem_rvalid) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end else if (tmr_q == TmrW'(LD_TIMEOUT - 1)) begin
          ld_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          tmr_d = TmrW'(tmr_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase

    wr_fire     = wr_en && (wr_addr != '0);
    gpr_we_d    = wr_fire;
    gpr_waddr_d = wr_fire ? wr_addr : gpr_waddr_q;
    gpr_wdata_d = wr_fire ? wr_data : gpr_wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ld_addr_q   <= '0;
      ld_size_q   <= '0;
      ld_sext_q   <= 1'b0;
      ld_off_q    <= '0;
      tmr_q       <= '0;
      ld_err_q    <= 1'b0;
      gpr_we_q    <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ld_addr_q   <= ld_addr_d;
      ld_size_q   <= ld_size_d;
      ld_sext_q   <= ld_sext_d;
      ld_off_q    <= ld_off_d;
      tmr_q       <= tmr_d;
      ld_err_q    <= ld_err_d;
      gpr_we_q    <= gpr_we_d;
      gpr_waddr_q <= gpr_waddr_d;
      gpr_wdata_q <= gpr_wdata_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == WAIT_LD);
  assign busy_addr = busy ? ld_addr_q : '0;
  assign ld_err    = ld_err_q;
  assign gpr_we    = gpr_we_q;
  assign gpr_waddr = gpr_waddr_q;
  assign gpr_wdata = gpr_wdata_q;

`ifdef GPR_WB_FWD_EN
  assign fwd_valid = wr_fire;
  assign fwd_addr  = wr_addr;
  assign fwd_data  = wr_data;
`endif

endmodule

// File: tb/tb_gpr_wb.sv
// Bench for gpr_wb: directed and random ALU/load traffic, writes checked by a cycle-stamped scoreboard.
module tb_gpr_wb;

  localparam int unsigned LdTo = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr_reg;
  logic        in_we;
  logic        in_is_load;
  logic [1:0]  in_ld_size;
  logic        in_ld_sext;
  logic [1:0]  in_ld_off;
  logic [31:0] in_alu_res;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        busy;
  logic [4:0]  busy_addr;
  logic        ld_err;
`ifdef GPR_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  gpr_wb #(.LD_TIMEOUT(LdTo)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr_reg (in_addr_reg),
    .in_we       (in_we),
    .in_is_load  (in_is_load),
    .in_ld_size  (in_ld_size),
    .in_ld_sext  (in_ld_sext),
    .in_ld_off   (in_ld_off),
    .in_alu_res  (in_alu_res),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .gpr_we      (gpr_we),
    .gpr_waddr   (gpr_waddr),
    .gpr_wdata   (gpr_wdata),
    .busy        (busy),
    .busy_addr   (busy_addr),
    .ld_err      (ld_err)
`ifdef GPR_WB_FWD_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load result: shift the addressed lane down, mask to its size, extend by arithmetic
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic sext, input logic [1:0] off);
    int unsigned nbytes;
    int unsigned shift;
    logic [31:0] v;
    logic [31:0] mask;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (nbytes == 4) return w;
    shift = (nbytes == 1) ? 8 * int'(off) : 16 * (int'(off) / 2);
    mask  = (32'd1 << (8 * nbytes)) - 32'd1;
    v     = (w >> shift) & mask;
    if (sext && v >= (32'd1 << (8 * nbytes - 1))) v = v | ~mask;
    return v;
  endfunction

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = cyc + 1;
    if (a != 5'd0) exp_q.push_back(e);
  endtask

  // Monitor: every write must match the head of the scoreboard in address, data and cycle
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (gpr_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(gpr_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(gpr_waddr), 32'(e.addr));
          chk("wr_data", gpr_wdata, e.data);
          chk("wr_cycle", cyc, e.cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_write", 32'(gpr_we), 32'd1);
      end
    end
  end

  task automatic issue_op(input logic [4:0] a, input logic [31:0] d, input logic we, input logic isld);
    chk("op_in_ready", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_addr_reg = a;
    in_we       = we;
    in_is_load  = isld;
    in_alu_res  = d;
    if (we && !isld) push_wr(a, d);
    tick();
  endtask

  task automatic issue_load(input logic [4:0] a, input logic [1:0] size, input logic sext,
                            input logic [1:0] off, input logic [31:0] w, input int delay,
                            input logic give, input logic hold, input logic [4:0] ha,
                            input logic [31:0] hd);
    chk("ld_in_ready", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_addr_reg = a;
    in_we       = 1'b1;
    in_is_load  = 1'b1;
    in_ld_size  = size;
    in_ld_sext  = sext;
    in_ld_off   = off;
    in_alu_res  = $urandom;
    tick();
    if (hold) begin
      in_valid    = 1'b1;
      in_is_load  = 1'b0;
      in_we       = 1'b1;
      in_addr_reg = ha;
      in_alu_res  = hd;
      in_ld_size  = 2'($urandom);
      in_ld_off   = 2'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    for (int i = 0; i < delay; i++) begin
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_busy_addr", 32'(busy_addr), 32'(a));
      chk("wait_in_ready", 32'(in_ready), 32'd0);
      mem_rdata = $urandom;
      tick();
    end
    if (give) begin
      chk("rv_busy", 32'(busy), 32'd1);
      mem_rvalid = 1'b1;
      mem_rdata  = w;
      push_wr(a, model_load(w, size, sext, off));
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      chk("wr_cycle_in_ready", 32'(in_ready), 32'd1);
      if (hold) begin
        push_wr(ha, hd);
        tick();
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ra;
    logic [31:0] rd;
    int unsigned kind;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_addr_reg = '0;
    in_we       = 1'b0;
    in_is_load  = 1'b0;
    in_ld_size  = '0;
    in_ld_sext  = 1'b0;
    in_ld_off   = '0;
    in_alu_res  = '0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_gpr_we", 32'(gpr_we), 32'd0);
    chk("rst_gpr_waddr", 32'(gpr_waddr), 32'd0);
    chk("rst_gpr_wdata", gpr_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_busy_addr", 32'(busy_addr), 32'd0);
    chk("rst_ld_err", 32'(ld_err), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single ALU write then three back-to-back
    issue_op(5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    issue_op(5'd1, 32'h11111111, 1'b1, 1'b0);
    issue_op(5'd2, 32'h22222222, 1'b1, 1'b0);
    issue_op(5'd3, 32'h33333333, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();

    // Lane extraction examples
    issue_load(5'd4, 2'b00, 1'b1, 2'd3, 32'h80123456, 0, 1'b1, 1'b0, 5'd0, 32'd0);
    issue_load(5'd6, 2'b01, 1'b0, 2'd2, 32'h80123456, 2, 1'b1, 1'b0, 5'd0, 32'd0);
    // Wait with a held ALU op behind it
    issue_load(5'd9, 2'b10, 1'b0, 2'd1, 32'hCAFEF00D, 3, 1'b1, 1'b1, 5'd10, 32'h00001234);
    // Data on the last allowed wait cycle
    issue_load(5'd11, 2'b11, 1'b1, 2'd0, 32'h0BADC0DE, int'(LdTo) - 1, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("final_cycle_no_err", 32'(ld_err), 32'd0);

    // r0 suppression and dropped load
    issue_op(5'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
    issue_load(5'd0, 2'b10, 1'b0, 2'd0, 32'h12345678, 1, 1'b1, 1'b0, 5'd0, 32'd0);
    issue_op(5'd3, 32'h55555555, 1'b0, 1'b1);
    in_valid = 1'b0;
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Timeout
    issue_load(5'd12, 2'b10, 1'b0, 2'd0, 32'd0, int'(LdTo), 1'b0, 1'b0, 5'd0, 32'd0);
    chk("timeout_ld_err", 32'(ld_err), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_in_ready", 32'(in_ready), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    tick();
    mem_rvalid = 1'b0;
    tick();

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      ra   = 5'($urandom);
      rd   = $urandom;
      if (kind < 5) begin
        issue_op(ra, rd, kind != 0, 1'b0);
      end else if (kind == 5) begin
        issue_op(ra, rd, 1'b0, 1'b1);
      end else begin
        issue_load(ra, 2'($urandom), 1'($urandom), 2'($urandom), rd,
                   int'($urandom_range(0, LdTo - 1)), 1'b1, $urandom_range(0, 3) == 0,
                   5'($urandom), $urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
    tick();
    tick();

    // Reset in the middle of a load
    chk("pre_reset_in_ready", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_addr_reg = 5'd7;
    in_we       = 1'b1;
    in_is_load  = 1'b1;
    in_ld_size  = 2'b10;
    tick();
    in_valid = 1'b0;
    tick();
    chk("midload_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_busy_addr", 32'(busy_addr), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_gpr_we", 32'(gpr_we), 32'd0);
    chk("mid_rst_gpr_waddr", 32'(gpr_waddr), 32'd0);
    chk("mid_rst_gpr_wdata", gpr_wdata, 32'd0);
    chk("mid_rst_ld_err", 32'(ld_err), 32'd0);
    tick();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A5A5A5;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gpr_wb.md
# gpr_wb

Write-back stage for the GPR file: the consumer end of the destination-register path whose `addr_reg` is selected in ID. It accepts retired ALU results and load requests from the MEM stage through a valid/ready handshake, waits for load data, performs byte/half/word lane extraction with sign or zero extension, and drives the single GPR write port. It also reports the in-flight destination so ID can stall on load-use hazards.

## Interface

Parameters:
- `LD_TIMEOUT`, 255: cycles to wait for `mem_rvalid` before abandoning a load; must be ≥ 1.
- Widths `GPR_BIT` and `GPR_ADR` come from `global_macro.v`; they are not parameters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  MEM stage presents a retiring instruction.
- `in_ready`  out  1  stage can accept; equals (state == IDLE).
- `in_addr_reg`  in  `GPR_ADR`  destination register.
- `in_we`  in  1  instruction writes a GPR.
- `in_is_load`  in  1  result comes from memory.
- `in_ld_size`  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- `in_ld_sext`  in  1  1 = sign-extend, 0 = zero-extend.
- `in_ld_off`  in  2  byte offset of load address.
- `in_alu_res`  in  `GPR_BIT`  ALU result.
- `mem_rvalid`  in  1  load data valid, single-cycle pulse.
- `mem_rdata`  in  `GPR_BIT`  load data word.
- `gpr_we`  out  1  register-file write enable.
- `gpr_waddr`  out  `GPR_ADR`  write address.
- `gpr_wdata`  out  `GPR_BIT`  write data.
- `busy`  out  1  a load is outstanding.
- `busy_addr`  out  `GPR_ADR`  destination of the outstanding load.
- `ld_err`  out  1  sticky load-timeout flag.

## Operation

- States: IDLE, WAIT_LD.
- IDLE: acceptance occurs when `in_valid & in_ready`.
  - If `!in_we`: the instruction is retired with no write.
  - If `in_we & !in_is_load`: `in_alu_res` is registered; stay in IDLE.
  - If `in_we & in_is_load`: latch address, size, sext and offset; clear the timer; go to WAIT_LD.
  - A load with `in_we = 0` is dropped. No wait occurs.
- WAIT_LD:
  - `in_ready = 0`, `busy = 1`, `busy_addr` = latched address.
  - On `mem_rvalid`, extract and extend, register the write, and go to IDLE.
  - Otherwise the timer increments. When the timer reaches `LD_TIMEOUT`, set `ld_err`, go to IDLE, and perform no write.
- Extraction:
  - Byte: lane `mem_rdata[8*off+7 : 8*off]`.
  - Half: `off[1]` selects the upper or lower 16 bits; `off[0]` is ignored.
  - Word: the full word.
  - Extension fills to `GPR_BIT` with the lane MSB (`in_ld_sext = 1`) or with zeros.
- Register 0 is hardwired: any write to address 0 is suppressed (`gpr_we` stays 0). A load to r0 still waits for its data.
- `mem_rvalid` in IDLE is ignored.

## Timing

- Reset values: state IDLE, `gpr_we` 0, `gpr_waddr` 0, `gpr_wdata` 0, `busy` 0, `busy_addr` 0, `ld_err` 0. `in_ready` is 1 during and after reset.
- ALU path: accept in cycle T, `gpr_we` high in T+1 for exactly one cycle. Back-to-back ALU ops sustain one write per cycle.
- Load path: accept in T; `mem_rvalid` is legal from T+1; write occurs in the cycle after `mem_rvalid`. `in_ready` returns high in that same write cycle.
- `mem_rvalid` arriving in the cycle the timer reaches `LD_TIMEOUT`: the data wins, the write occurs, and `ld_err` is not set.
- `ld_err` clears only on reset.
- Reset mid-load: the pending load is discarded and no write is issued.

## Configuration

- `GPR_WB_FWD_EN` defined:
  - Adds outputs `fwd_valid` (1), `fwd_addr` (`GPR_ADR`) and `fwd_data` (`GPR_BIT`).
  - These combinationally present the value to be written, one cycle before `gpr_we`: in the acceptance cycle for ALU ops and in the `mem_rvalid` cycle for loads.
  - `fwd_valid` is 0 for address 0 and for dropped instructions.
- Not defined: the ports are absent, and ID relies on `busy` and the register file alone.

## Test plan

- ALU op, addr 5, res 0xDEADBEEF, accepted at T → `gpr_we` = 1, `gpr_waddr` = 5, `gpr_wdata` = 0xDEADBEEF at T+1 only. Three consecutive ALU ops → three consecutive writes.
- Sign-extended byte load, off = 3, `mem_rdata` = 0x80123456 → `gpr_wdata` = 0xFFFFFF80. Zero-extended half load, off = 2 → `gpr_wdata` = 0x00008012.
- Load to addr 9 → `busy` = 1 and `busy_addr` = 9 while waiting, `in_ready` = 0. `in_valid` held high during the wait is not accepted until the write cycle.
- Load with no `mem_rvalid` for `LD_TIMEOUT` cycles → `ld_err` = 1, no `gpr_we`, return to IDLE. Repeat with `mem_rvalid` on the final cycle → write occurs and `ld_err` stays 0.
- ALU write to addr 0, and a load to addr 0 → `gpr_we` never asserts. Assert `rst_n` low mid-load → all outputs return to reset values and no write occurs after release.
